// File: rtl/mesi_cmd_sequencer.sv
// Trace command sequencer: buffers {code, hit} pairs in a small FIFO and decodes them
// in order into MESI event codes, clear/print strobes, or a sticky illegal-code flag.
module mesi_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_code,
   input  logic        cmd_hit,
   output logic [2:0]  inbits,
   output logic        inbits_valid,
   input  logic        inbits_ready,
   output logic        clear_pulse,
   output logic        print_pulse,
   output logic        err_cmd,
   output logic [15:0] evt_count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {
      ST_EMPTY,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic [3:0] code;
      logic       hit;
   } cmd_t;

   cmd_t        fifo_mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   state_t      state_q, state_d;
   logic [2:0]  inbits_q, inbits_d;
   logic        clear_pulse_q, clear_pulse_d;
   logic        print_pulse_q, print_pulse_d;
   logic        err_cmd_q, err_cmd_d;
   logic [15:0] evt_count_q, evt_count_d;

   logic fifo_full, fifo_empty, push, pop, out_hs, out_free;
   cmd_t head;
   logic       head_is_event, head_is_clear, head_is_print, head_is_illegal;
   logic [2:0] head_evt;

   // Extra MSB on each pointer separates full (MSBs differ) from empty (all equal).
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign cmd_ready    = !fifo_full && !reset;
   assign push         = cmd_valid && cmd_ready;
   assign inbits_valid = (state_q == ST_HOLD);
   assign out_hs       = inbits_valid && inbits_ready;
   assign out_free     = (state_q == ST_EMPTY) || out_hs;
   assign pop          = !fifo_empty && out_free;
   assign head         = fifo_mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      head_is_event   = 1'b0;
      head_is_clear   = 1'b0;
      head_is_print   = 1'b0;
      head_is_illegal = 1'b0;
      head_evt        = 3'b000;
      case (head.code)
         4'd0, 4'd2: begin head_is_event = 1'b1; head_evt = head.hit ? 3'b000 : 3'b001; end
         4'd1:       begin head_is_event = 1'b1; head_evt = head.hit ? 3'b010 : 3'b011; end
         4'd3:       begin head_is_event = 1'b1; head_evt = 3'b100; end
         4'd4:       begin head_is_event = 1'b1; head_evt = 3'b101; end
         4'd5:       begin head_is_event = 1'b1; head_evt = 3'b110; end
         4'd6:       begin head_is_event = 1'b1; head_evt = 3'b111; end
         4'd8:       head_is_clear   = 1'b1;
         4'd9:       head_is_print   = 1'b1;
         default:    head_is_illegal = 1'b1;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      wr_ptr_d      = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d      = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      state_d       = state_q;
      inbits_d      = inbits_q;
      clear_pulse_d = pop && head_is_clear;
      print_pulse_d = pop && head_is_print;
      err_cmd_d     = err_cmd_q || (pop && head_is_illegal);
      evt_count_d   = out_hs ? evt_count_q + 16'd1 : evt_count_q;
      if (out_hs) begin
         state_d = ST_EMPTY;
      end
      // A new event popping on the handshake edge keeps the stage in HOLD back to back.
      if (pop && head_is_event) begin
         state_d  = ST_HOLD;
         inbits_d = head_evt;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         state_q       <= ST_EMPTY;
         inbits_q      <= 3'b000;
         clear_pulse_q <= 1'b0;
         print_pulse_q <= 1'b0;
         err_cmd_q     <= 1'b0;
         evt_count_q   <= 16'd0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         state_q       <= state_d;
         inbits_q      <= inbits_d;
         clear_pulse_q <= clear_pulse_d;
         print_pulse_q <= print_pulse_d;
         err_cmd_q     <= err_cmd_d;
         evt_count_q   <= evt_count_d;
      end
   end

   // NOTE: storage is left unreset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q[AW-1:0]] <= '{code: cmd_code, hit: cmd_hit};
      end
   end

   assign inbits      = inbits_q;
   assign clear_pulse = clear_pulse_q;
   assign print_pulse = print_pulse_q;
   assign err_cmd     = err_cmd_q;
   assign evt_count   = evt_count_q;

endmodule

// File: tb/tb_mesi_cmd_sequencer.sv
// Scoreboard bench for mesi_cmd_sequencer: accepted commands push expected outputs,
// observed events and strobes pop and compare them in order.
module tb_mesi_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_code;
   logic        cmd_hit;
   logic [2:0]  inbits;
   logic        inbits_valid;
   logic        inbits_ready;
   logic        clear_pulse;
   logic        print_pulse;
   logic        err_cmd;
   logic [15:0] evt_count;

   int checks = 0;
   int errors = 0;

   // Scoreboard item: {kind[1:0], value[2:0]}; kind 1 = event, 2 = clear, 3 = print.
   logic [4:0] sb_q[$];

   mesi_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_code     (cmd_code),
      .cmd_hit      (cmd_hit),
      .inbits       (inbits),
      .inbits_valid (inbits_valid),
      .inbits_ready (inbits_ready),
      .clear_pulse  (clear_pulse),
      .print_pulse  (print_pulse),
      .err_cmd      (err_cmd),
      .evt_count    (evt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] expect_item(input logic [3:0] code, input logic hit);
      case (code)
         4'd0, 4'd2: return hit ? 5'b01_000 : 5'b01_001;
         4'd1:       return hit ? 5'b01_010 : 5'b01_011;
         4'd3:       return 5'b01_100;
         4'd4:       return 5'b01_101;
         4'd5:       return 5'b01_110;
         4'd6:       return 5'b01_111;
         4'd8:       return 5'b10_000;
         4'd9:       return 5'b11_000;
         default:    return 5'b00_000;
      endcase
   endfunction

   task automatic observe(input string tag, input logic [4:0] item);
      logic [4:0] exp;
      if (sb_q.size() == 0) begin
         check({tag, "_spurious"}, item, 5'b00_000);
      end else begin
         exp = sb_q.pop_front();
         check(tag, item, exp);
      end
   endtask

   // Monitor: samples mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid && cmd_ready && expect_item(cmd_code, cmd_hit) != 5'b0)
            sb_q.push_back(expect_item(cmd_code, cmd_hit));
         if (clear_pulse) observe("clr", 5'b10_000);
         if (print_pulse) observe("prt", 5'b11_000);
         if (inbits_valid && inbits_ready) observe("evt", {2'b01, inbits});
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [3:0] code, input logic hit);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      cmd_valid = 1'b1;
      cmd_code  = code;
      cmd_hit   = hit;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain", sb_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      cmd_valid    = 1'b0;
      inbits_ready = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      cmd_valid    = 1'b0;
      cmd_code     = 4'd0;
      cmd_hit      = 1'b0;
      inbits_ready = 1'b0;
      #2;
      check("rst_valid", inbits_valid, 1'b0);
      check("rst_inbits", inbits, 3'b000);
      check("rst_ready", cmd_ready, 1'b0);
      check("rst_pulses", {clear_pulse, print_pulse}, 2'b00);
      check("rst_err", err_cmd, 1'b0);
      check("rst_cnt", evt_count, 16'd0);
      do_reset();

      // Latency and back-to-back throughput.
      inbits_ready = 1'b1;
      send(4'd0, 1'b0);
      send(4'd1, 1'b1);
      check("lat_valid", inbits_valid, 1'b1);
      check("lat_first", inbits, 3'b001);
      @(posedge clk);
      #1;
      check("lat_second", inbits, 3'b010);
      check("lat_second_valid", inbits_valid, 1'b1);
      drain(20);
      check("lat_cnt", evt_count, 16'd2);

      // Backpressure: 1 held + 4 queued, the sixth refused.
      do_reset();
      send(4'd0, 1'b0);
      send(4'd1, 1'b1);
      send(4'd2, 1'b1);
      send(4'd5, 1'b0);
      send(4'd6, 1'b1);
      cmd_valid = 1'b1;
      cmd_code  = 4'd3;
      cmd_hit   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_full_ready", cmd_ready, 1'b0);
         check("bp_hold_inbits", inbits, 3'b001);
         check("bp_hold_valid", inbits_valid, 1'b1);
      end
      @(posedge clk);
      #1;
      cmd_valid    = 1'b0;
      inbits_ready = 1'b1;
      drain(30);
      check("bp_cnt", evt_count, 16'd5);

      // Illegal code followed by a legal one.
      do_reset();
      inbits_ready = 1'b1;
      send(4'd7, 1'b0);
      send(4'd4, 1'b0);
      drain(20);
      check("ill_err", err_cmd, 1'b1);
      check("ill_cnt", evt_count, 16'd1);
      repeat (3) @(posedge clk);
      #1;
      check("ill_err_sticky", err_cmd, 1'b1);

      // Strobes wait behind an unacknowledged event.
      do_reset();
      send(4'd3, 1'b0);
      send(4'd8, 1'b0);
      send(4'd9, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("nev_no_pulse", {clear_pulse, print_pulse}, 2'b00);
         check("nev_hold", {inbits_valid, inbits}, 4'b1_100);
      end
      @(posedge clk);
      #1;
      inbits_ready = 1'b1;
      @(negedge clk);
      check("nev_pulse_after_hs", {clear_pulse, print_pulse}, 2'b00);
      @(negedge clk);
      check("nev_clear", {clear_pulse, print_pulse}, 2'b10);
      @(negedge clk);
      check("nev_print", {clear_pulse, print_pulse}, 2'b01);
      drain(10);
      check("nev_cnt", evt_count, 16'd1);

      // Asynchronous reset mid-operation.
      do_reset();
      send(4'd7, 1'b0);
      send(4'd1, 1'b0);
      send(4'd4, 1'b1);
      send(4'd0, 1'b1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("mid_valid", inbits_valid, 1'b0);
      check("mid_inbits", inbits, 3'b000);
      check("mid_ready", cmd_ready, 1'b0);
      check("mid_err", err_cmd, 1'b0);
      check("mid_cnt", evt_count, 16'd0);
      check("mid_pulses", {clear_pulse, print_pulse}, 2'b00);
      sb_q.delete();
      @(posedge clk);
      #1;
      reset        = 1'b0;
      inbits_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mid_no_event", inbits_valid, 1'b0);
      end
      @(posedge clk);
      #1;

      // Event counter wraps after 65536 handshakes.
      do_reset();
      inbits_ready = 1'b1;
      for (int i = 0; i < 65536; i++) send(4'd3, 1'b0);
      drain(20);
      check("wrap_cnt", evt_count, 16'd0);
      check("wrap_err", err_cmd, 1'b0);
      check("wrap_idle", inbits_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
